// File: rtl/ctu_seq_if.sv
// Control/status bundle between the ctu run sequencer and its surroundings
// (button pulses in, counter controls and run status out).
interface ctu_seq_if #(
  parameter int unsigned NR_OVF_BITI = 4,
  parameter int unsigned NR_LAP_BITI = 4
);
  logic                   start_i;
  logic                   dir_i;
  logic                   clr_i;
  logic                   ovf_i;
  logic                   enable_o;
  logic                   count_up_o;
  logic [1:0]             state_o;
  logic [NR_OVF_BITI-1:0] ovf_cnt_o;
  logic                   done_o;
  logic [NR_LAP_BITI-1:0] lap_o;

  // The sequencer side.
  modport slave (
    input  start_i, dir_i, clr_i, ovf_i,
    output enable_o, count_up_o, state_o, ovf_cnt_o, done_o, lap_o
  );

  // The side that drives the button pulses and observes the status.
  modport master (
    output start_i, dir_i, clr_i, ovf_i,
    input  enable_o, count_up_o, state_o, ovf_cnt_o, done_o, lap_o
  );
endinterface

// File: rtl/ctu_seq.sv
// Run/pause/stop sequencer for the ctu up/down counter; counts overflows per run and completed runs.
// Optional feature: define CTU_SEQ_AUTORESTART_EN to restart a run automatically one cycle after DONE.
module ctu_seq #(
  parameter int unsigned NR_OVF_BITI = 4,
  parameter int unsigned N_OVF       = 3,
  parameter int unsigned NR_LAP_BITI = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  ctu_seq_if.slave   bus
);

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [NR_OVF_BITI-1:0] OVF_LAST = NR_OVF_BITI'(N_OVF - 1);
  localparam logic [NR_OVF_BITI-1:0] OVF_FULL = NR_OVF_BITI'(N_OVF);
  localparam logic [NR_OVF_BITI-1:0] OVF_ONE  = NR_OVF_BITI'(1);
  localparam logic [NR_LAP_BITI-1:0] LAP_ONE  = NR_LAP_BITI'(1);

  state_t                 state;
  logic                   enable;
  logic                   count_up;
  logic [NR_OVF_BITI-1:0] ovf_cnt;
  logic                   done;
  logic [NR_LAP_BITI-1:0] lap;

  logic ovf_terminal;
  assign ovf_terminal = bus.ovf_i && (ovf_cnt == OVF_LAST);

  // Sequencer: state and every output update together, so enable follows state with no lag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      enable   <= 1'b0;
      count_up <= 1'b1;
      ovf_cnt  <= '0;
      done     <= 1'b0;
      lap      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.clr_i) begin
            ovf_cnt <= '0;
          end else if (bus.start_i) begin
            state   <= ST_RUN;
            enable  <= 1'b1;
            ovf_cnt <= '0;
          end else if (bus.dir_i) begin
            count_up <= ~count_up;
          end
        end

        // Direction is frozen while the counter is enabled.
        ST_RUN: begin
          if (bus.clr_i) begin
            state   <= ST_IDLE;
            enable  <= 1'b0;
            ovf_cnt <= '0;
          end else if (ovf_terminal) begin
            state   <= ST_DONE;
            enable  <= 1'b0;
            ovf_cnt <= OVF_FULL;
            done    <= 1'b1;
            lap     <= lap + LAP_ONE;
          end else begin
            if (bus.ovf_i) begin
              ovf_cnt <= ovf_cnt + OVF_ONE;
            end
            if (bus.start_i) begin
              state  <= ST_PAUSE;
              enable <= 1'b0;
            end
          end
        end

        // Counter is disabled here, so any stray overflow pulse is dropped.
        ST_PAUSE: begin
          if (bus.clr_i) begin
            state   <= ST_IDLE;
            ovf_cnt <= '0;
          end else if (bus.start_i) begin
            state  <= ST_RUN;
            enable <= 1'b1;
          end else if (bus.dir_i) begin
            count_up <= ~count_up;
          end
        end

        ST_DONE: begin
          if (bus.clr_i || bus.start_i) begin
            state   <= ST_IDLE;
            ovf_cnt <= '0;
          end else begin
`ifdef CTU_SEQ_AUTORESTART_EN
            state   <= ST_RUN;
            enable  <= 1'b1;
            ovf_cnt <= '0;
`else
            state   <= ST_DONE;
`endif
          end
        end

        default: begin
          state   <= ST_IDLE;
          enable  <= 1'b0;
          ovf_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.state_o    = state;
  assign bus.enable_o   = enable;
  assign bus.count_up_o = count_up;
  assign bus.ovf_cnt_o  = ovf_cnt;
  assign bus.done_o     = done;
  assign bus.lap_o      = lap;

endmodule
